// File: rtl/free_list_pkg.sv
// free_list_pkg: shared widths, types and helpers for the physical-register free list.
//   PHY_REG_SEL    - physical tag width (NUM_PHY_REGS = 2**PHY_REG_SEL)
//   REG_SEL        - architectural register index width
//   FL_PTR_W       - free-list pointer width (index bits + wrap bit)
//   RESET_TAG_BASE - first tag placed in the list at reset
package free_list_pkg;

  localparam int unsigned PHY_REG_SEL    = 6;
  localparam int unsigned REG_SEL        = 5;
  localparam int unsigned NUM_PHY_REGS   = 1 << PHY_REG_SEL;
  localparam int unsigned NUM_ARCH_REGS  = 1 << REG_SEL;
  localparam int unsigned DEPTH          = NUM_PHY_REGS - NUM_ARCH_REGS;
  localparam int unsigned IDX_W          = $clog2(DEPTH);
  localparam int unsigned FL_PTR_W       = IDX_W + 1;
  localparam int unsigned RESET_TAG_BASE = NUM_ARCH_REGS;

  typedef logic [PHY_REG_SEL-1:0] phy_tag_t;
  typedef logic [FL_PTR_W-1:0]    fl_ptr_t;
  typedef logic [IDX_W-1:0]       fl_idx_t;
  typedef logic [1:0]             fl_inc_t;

  // Number of asserted lanes in a 2-wide group (0, 1 or 2).
  function automatic fl_inc_t pair_count(input logic a, input logic b);
    return fl_inc_t'(a) + fl_inc_t'(b);
  endfunction

endpackage

// File: rtl/free_list_if.sv
// free_list_if: rename/commit-side bundle of the free list.
//   master - rename + commit logic (drives requests, releases, flush)
//   slave  - the free list (drives offered tags, ready, count, error)
interface free_list_if;
  import free_list_pkg::*;

  logic     alloc_req_1;
  logic     alloc_req_2;
  logic     alloc_fire;
  phy_tag_t phy_dst_1;
  phy_tag_t phy_dst_2;
  logic     alloc_ready;
  logic     commit_alloc_1;
  logic     commit_alloc_2;
  logic     release_valid_1;
  logic     release_valid_2;
  phy_tag_t release_tag_1;
  phy_tag_t release_tag_2;
  logic     flush;
  fl_ptr_t  free_count;
  logic     fl_error;

  modport master (
    output alloc_req_1, alloc_req_2, alloc_fire,
    output commit_alloc_1, commit_alloc_2,
    output release_valid_1, release_valid_2, release_tag_1, release_tag_2,
    output flush,
    input  phy_dst_1, phy_dst_2, alloc_ready, free_count, fl_error
  );

  modport slave (
    input  alloc_req_1, alloc_req_2, alloc_fire,
    input  commit_alloc_1, commit_alloc_2,
    input  release_valid_1, release_valid_2, release_tag_1, release_tag_2,
    input  flush,
    output phy_dst_1, phy_dst_2, alloc_ready, free_count, fl_error
  );

endinterface

// File: rtl/free_list_ptr.sv
// free_list_ptr: wrap-bit circular pointer with a 0/1/2 increment and a load.
//   clk, reset - clock, async active-high reset (pointer <= RESET_VAL)
//   inc        - amount to advance this cycle
//   load       - replace the pointer with load_val (overrides inc)
//   ptr        - registered pointer value
module free_list_ptr
  import free_list_pkg::*;
#(
  parameter fl_ptr_t RESET_VAL = '0
) (
  input  logic    clk,
  input  logic    reset,
  input  fl_inc_t inc,
  input  logic    load,
  input  fl_ptr_t load_val,
  output fl_ptr_t ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ptr <= RESET_VAL;
    else if (load) ptr <= load_val;
    else           ptr <= ptr + FL_PTR_W'(inc);
  end

endmodule

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags for a 2-wide rename.
//   clk, reset - clock, async active-high reset
//   fl         - free_list_if.slave: allocation requests/offered tags,
//                commit and release from retirement, flush, count, error
// Optional build macro FREELIST_CHECK_EN adds an is_free bitmap and a sticky
// fl_error for underflow, overflow, double-free and commit overrun.
module free_list
  import free_list_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  free_list_if.slave  fl
);

  fl_ptr_t  head;
  fl_ptr_t  commit_head;
  fl_ptr_t  tail;
  fl_ptr_t  commit_head_nxt;
  fl_ptr_t  free_count;
  fl_inc_t  alloc_n;
  fl_inc_t  alloc_step;
  fl_inc_t  rel_n;
  fl_inc_t  commit_n;
  logic     alloc_ready;
  logic     alloc_go;
  phy_tag_t dst_1;
  phy_tag_t dst_2;
  fl_idx_t  rd_idx_0;
  fl_idx_t  rd_idx_1;
  fl_idx_t  wr_idx_0;
  fl_idx_t  wr_idx_1;
  phy_tag_t mem [DEPTH];

  // Request accounting and allocation gating.
  always_comb begin
    alloc_n     = pair_count(fl.alloc_req_1, fl.alloc_req_2);
    rel_n       = pair_count(fl.release_valid_1, fl.release_valid_2);
    commit_n    = pair_count(fl.commit_alloc_1, fl.commit_alloc_2);
    free_count  = tail - head;
    alloc_ready = free_count >= FL_PTR_W'(alloc_n);
    alloc_go    = fl.alloc_fire && alloc_ready && !fl.flush;
    alloc_step  = alloc_go ? alloc_n : 2'd0;
    // Flush lands on the committed head including this cycle's commits.
    commit_head_nxt = commit_head + FL_PTR_W'(commit_n);
  end

  free_list_ptr #(.RESET_VAL('0)) u_head (
    .clk      (clk),
    .reset    (reset),
    .inc      (alloc_step),
    .load     (fl.flush),
    .load_val (commit_head_nxt),
    .ptr      (head)
  );

  free_list_ptr #(.RESET_VAL('0)) u_commit_head (
    .clk      (clk),
    .reset    (reset),
    .inc      (commit_n),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (commit_head)
  );

  free_list_ptr #(.RESET_VAL(fl_ptr_t'(DEPTH))) u_tail (
    .clk      (clk),
    .reset    (reset),
    .inc      (rel_n),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (tail)
  );

  // Read path: slot 2 takes the head entry when slot 1 is not requesting.
  always_comb begin
    rd_idx_0 = head[IDX_W-1:0];
    rd_idx_1 = rd_idx_0 + IDX_W'(1);
    dst_1    = '0;
    dst_2    = '0;
    if (fl.alloc_req_1) begin
      dst_1 = mem[rd_idx_0];
      if (fl.alloc_req_2) dst_2 = mem[rd_idx_1];
    end else if (fl.alloc_req_2) begin
      dst_2 = mem[rd_idx_0];
    end
  end

  // Release writes: lane 1 takes the lower slot, a lone lane 2 takes tail.
  always_comb begin
    wr_idx_0 = tail[IDX_W-1:0];
    wr_idx_1 = wr_idx_0 + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= phy_tag_t'(int'(RESET_TAG_BASE) + i);
      end
    end else begin
      if (fl.release_valid_1) mem[wr_idx_0] <= fl.release_tag_1;
      if (fl.release_valid_2) mem[fl.release_valid_1 ? wr_idx_1 : wr_idx_0] <= fl.release_tag_2;
    end
  end

  assign fl.phy_dst_1   = dst_1;
  assign fl.phy_dst_2   = dst_2;
  assign fl.alloc_ready = alloc_ready;
  assign fl.free_count  = free_count;

`ifdef FREELIST_CHECK_EN
  localparam int unsigned CNT_W = FL_PTR_W + 1;

  logic [NUM_PHY_REGS-1:0] is_free;
  logic [NUM_PHY_REGS-1:0] is_free_nxt;
  logic [CNT_W-1:0]        count_nxt;
  logic [CNT_W-1:0]        outstanding;
  fl_ptr_t                 squash_n;
  fl_ptr_t                 sq_ptr;
  logic                    err_alloc;
  logic                    err_over;
  logic                    err_dfree;
  logic                    err_commit;
  logic                    err_any;
  logic                    fl_error_q;

  // Error detection for this cycle's traffic.
  always_comb begin
    count_nxt   = CNT_W'(free_count) + CNT_W'(rel_n) - CNT_W'(alloc_step);
    outstanding = CNT_W'(fl_ptr_t'(head - commit_head)) + CNT_W'(alloc_step);
    err_alloc   = fl.alloc_fire && !alloc_ready && !fl.flush;
    err_over    = count_nxt > CNT_W'(DEPTH);
    err_dfree   = (fl.release_valid_1 && is_free[fl.release_tag_1]) ||
                  (fl.release_valid_2 && is_free[fl.release_tag_2]) ||
                  (fl.release_valid_1 && fl.release_valid_2 &&
                   (fl.release_tag_1 == fl.release_tag_2));
    err_commit  = CNT_W'(commit_n) > outstanding;
    err_any     = err_alloc || err_over || err_dfree || err_commit;
  end

  // is_free tracking: allocations clear, flushed entries and releases set.
  always_comb begin
    is_free_nxt = is_free;
    squash_n    = head - commit_head_nxt;
    sq_ptr      = '0;
    if (alloc_go) begin
      if (fl.alloc_req_1) is_free_nxt[dst_1] = 1'b0;
      if (fl.alloc_req_2) is_free_nxt[dst_2] = 1'b0;
    end
    if (fl.flush) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        sq_ptr = commit_head_nxt + FL_PTR_W'(i);
        if (FL_PTR_W'(i) < squash_n) is_free_nxt[mem[sq_ptr[IDX_W-1:0]]] = 1'b1;
      end
    end
    if (fl.release_valid_1) is_free_nxt[fl.release_tag_1] = 1'b1;
    if (fl.release_valid_2) is_free_nxt[fl.release_tag_2] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_free    <= {{DEPTH{1'b1}}, {NUM_ARCH_REGS{1'b0}}};
      fl_error_q <= 1'b0;
    end else begin
      is_free <= is_free_nxt;
      if (err_any) begin
        if (!fl_error_q) $error("free_list: integrity violation (alloc=%0b over=%0b dfree=%0b commit=%0b)",
                                err_alloc, err_over, err_dfree, err_commit);
        fl_error_q <= 1'b1;
      end
    end
  end

  assign fl.fl_error = fl_error_q;
`else
  assign fl.fl_error = 1'b0;
`endif

endmodule
